sdcard_arbiter: RTL and testbench
=================================

Name: sdcard_arbiter

Overview:
- Shares the single physical SD card SPI port between several controllers (paper punch, reader, disk emulators).
- Each controller owns its own SPI engine and uses an sdreq/sdack handshake.
- The arbiter grants the card to one requester at a time, round-robin, and muxes that requester's cs/mosi/sclk onto the card pins.
- After each release it inserts a guard interval so that card framing is never corrupted.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- GUARD, 8: clk_p cycles with card deselected after each release, >=1.
- TIMEOUT, 24'd12000000: clk_p cycles a grant may be held. Used only with SDARB_TIMEOUT_EN.

Ports:
- clk_p  in  1  system clock; all logic on posedge.
- sys_init_n  in  1  asynchronous active-low reset.
- sdreq  in  NREQ  per-requester access request, level; held for the whole transaction.
- sdack  out  NREQ  per-requester grant, one-hot or zero, registered.
- req_cs  in  NREQ  per-requester SPI chip select.
- req_mosi  in  NREQ  per-requester SPI data out.
- req_sclk  in  NREQ  per-requester SPI clock.
- req_miso  out  NREQ  per-requester SPI data in.
- sdcard_cs  out  1  card chip select, active low.
- sdcard_mosi  out  1  card data in.
- sdcard_sclk  out  1  card clock.
- sdcard_miso  in  1  card data out.
- owner  out  3  index of current grantee; valid when busy=1.
- busy  out  1  a grant is active.
- timeout  out  1  one-cycle pulse on a forced release (0 when feature absent).

Behaviour:
- Reset (asynchronous, sys_init_n=0):
  - sdack=0, busy=0, owner=0, timeout=0.
  - State=S_IDLE, rr pointer=0.
  - Card pins: cs=1, mosi=1, sclk=0.
- States: S_IDLE, S_GRANT, S_GUARD.
- S_IDLE:
  - If any sdreq bit is set, pick the first set bit searching from (last_owner+1) mod NREQ upward with wrap.
  - Set owner, set sdack[owner]=1, set busy=1, go to S_GRANT.
  - Latency: sdreq sampled high at edge t gives sdack high after edge t+1, i.e. one cycle.
- S_GRANT:
  - Card pins = req_cs[owner], req_mosi[owner], req_sclk[owner], combinationally from the owner register.
  - req_miso[owner]=sdcard_miso; every other req_miso bit =1.
  - When sdreq[owner]=0: clear sdack, set busy=0, last_owner=owner, load guard counter with GUARD-1, go to S_GUARD.
  - sdreq changes on other requesters are ignored (no preemption).
- S_GUARD:
  - Card pins forced to cs=1, mosi=1, sclk=0; all req_miso=1.
  - Counter decrements each cycle; at 0 go to S_IDLE.
  - New requests are only evaluated in S_IDLE, so the minimum gap between successive grants is GUARD+1 cycles.
- Outside S_GRANT the card pins always hold the idle levels (cs=1, mosi=1, sclk=0).
- Boundary conditions:
  - Simultaneous requests are resolved strictly by the rr pointer. A requester that re-raises sdreq right after release loses to any other pending requester.
  - Single requester: regrant after GUARD+1 cycles.
  - NREQ not a power of two: the wrap uses mod NREQ; indices >= NREQ are never selected.
  - sdreq deasserted in the same cycle the grant is issued: sdack pulses for one cycle, then the block enters S_GUARD.
  - Reset mid-grant: sdack drops and cs goes high asynchronously. The requester is responsible for its own recovery.
- owner width is fixed at 3. Upper bits are 0 when NREQ<8.

Optional Feature:
- Macro: SDARB_TIMEOUT_EN.
- Defined:
  - A 24-bit counter clears on entering S_GRANT and increments each S_GRANT cycle.
  - On reaching TIMEOUT-1, the arbiter forces release exactly as if sdreq[owner] fell, and pulses timeout for 1 cycle.
  - The timed-out requester is masked from selection until its sdreq is observed low for at least one cycle.
- Undefined: no counter or mask logic exists, timeout is tied to 0, and a grant is held indefinitely.

Decomposition:
- Package sdarb_pkg:
  - State enum S_IDLE/S_GRANT/S_GUARD (2 bits).
  - Localparam IDLE_CS=1, IDLE_MOSI=1, IDLE_SCLK=0.
  - Owner width constant OWN_W=3.
- One sub-module: sdarb_rr_pick.
  - Combinational round-robin picker.
  - Inputs: req vector, mask vector, last_owner.
  - Outputs: found, index.
  - Reused by future bus arbiters.

Test Plan:
- Single request: sdreq=4'b0010 at cycle 10 -> sdack=4'b0010 at cycle 11. Card pins follow req_*[1]; req_miso[0,2,3]=1.
- Contention: sdreq=4'b1011 held, each grant released after 20 cycles -> grant order 0,1,3,0. Gap between sdack edges = GUARD+1 = 9 cycles, with cs=1 and sclk=0 in each gap.
- Back-to-back same requester: req 2 releases, then re-raises immediately while req 0 is pending -> req 0 granted next, then req 2.
- Reset mid-grant: sys_init_n low while sdack=4'b0100 -> sdack=0 and sdcard_cs=1 before the next clock edge; after release, first grant goes to the lowest set bit searching from index 1.
- Timeout (SDARB_TIMEOUT_EN, TIMEOUT=100): req 3 holds sdreq -> sdack[3] falls after 100 grant cycles with a one-cycle timeout pulse. Req 3 is not regranted until sdreq[3] goes 0 then 1.
- Glitch request: sdreq[1] high for 1 cycle in S_IDLE -> sdack[1] one-cycle pulse, followed by a full GUARD interval.

Source files
------------

// File: rtl/sdarb_pkg.sv
// Shared types and constants for the SD card port arbiter.
package sdarb_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GUARD = 2'd2
  } state_t;

  localparam logic IDLE_CS   = 1'b1;
  localparam logic IDLE_MOSI = 1'b1;
  localparam logic IDLE_SCLK = 1'b0;
  localparam int   OWN_W     = 3;
endpackage

// File: rtl/sdarb_rr_pick.sv
// Combinational round-robin picker: first unmasked request after last_owner,
// wrapping modulo N, so indices >= N are never produced.
module sdarb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] last_owner,
  output logic          found,
  output logic [IW-1:0] index
);
  logic [N-1:0] cand;
  int           j;

  assign cand = req & ~mask;

  always_comb begin
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(last_owner) + 1 + i;
      if (j >= N) j = j - N;
      if (!found && cand[j]) begin
        found = 1'b1;
        index = IW'(j);
      end
    end
  end
endmodule

// File: rtl/sdcard_arbiter.sv
// Round-robin owner of the shared SD card SPI port with a post-release guard.
// Optional forced release of long grants under SDARB_TIMEOUT_EN.
module sdcard_arbiter
  import sdarb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int GUARD = 8
`ifdef SDARB_TIMEOUT_EN
  , parameter logic [23:0] TIMEOUT = 24'd12000000
`endif
) (
  input  logic             clk_p,
  input  logic             sys_init_n,
  input  logic [NREQ-1:0]  sdreq,
  output logic [NREQ-1:0]  sdack,
  input  logic [NREQ-1:0]  req_cs,
  input  logic [NREQ-1:0]  req_mosi,
  input  logic [NREQ-1:0]  req_sclk,
  output logic [NREQ-1:0]  req_miso,
  output logic             sdcard_cs,
  output logic             sdcard_mosi,
  output logic             sdcard_sclk,
  input  logic             sdcard_miso,
  output logic [OWN_W-1:0] owner,
  output logic             busy,
  output logic             timeout
);
  localparam int IW = $clog2(NREQ);
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  state_t          state_q, state_d;
  logic [IW-1:0]   own_q, own_d, last_q, last_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            busy_q, busy_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic [NREQ-1:0] mask;
  logic            force_rel;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            granted;

  sdarb_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req        (sdreq),
    .mask       (mask),
    .last_owner (last_q),
    .found      (pick_found),
    .index      (pick_idx)
  );

`ifdef SDARB_TIMEOUT_EN
  logic [23:0]     tcnt_q, tcnt_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic            tmo_q, tmo_d;

  assign force_rel = (state_q == S_GRANT) && (tcnt_q == TIMEOUT - 24'd1);

  // A timed-out requester stays masked until it is seen with sdreq low.
  always_comb begin
    tcnt_d = (state_q == S_GRANT) ? tcnt_q + 24'd1 : '0;
    mask_d = mask_q & sdreq;
    tmo_d  = force_rel;
    if (force_rel) mask_d[own_q] = sdreq[own_q];
  end

  always_ff @(posedge clk_p or negedge sys_init_n) begin
    if (!sys_init_n) begin
      tcnt_q <= '0;
      mask_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      mask_q <= mask_d;
      tmo_q  <= tmo_d;
    end
  end

  assign mask    = mask_q;
  assign timeout = tmo_q;
`else
  assign force_rel = 1'b0;
  assign mask      = '0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      S_IDLE: if (pick_found) begin
        own_d           = pick_idx;
        ack_d           = '0;
        ack_d[pick_idx] = 1'b1;
        busy_d          = 1'b1;
        state_d         = S_GRANT;
      end
      S_GRANT: if (!sdreq[own_q] || force_rel) begin
        ack_d   = '0;
        busy_d  = 1'b0;
        last_d  = own_q;
        gcnt_d  = GW'(GUARD - 1);
        state_d = S_GUARD;
      end
      S_GUARD: begin
        if (gcnt_q == '0) state_d = S_IDLE;
        else              gcnt_d  = gcnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_p or negedge sys_init_n) begin
    if (!sys_init_n) begin
      state_q <= S_IDLE;
      own_q   <= '0;
      last_q  <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Pins are muxed straight from the owner register so SPI timing is untouched.
  assign granted = (state_q == S_GRANT);

  always_comb begin
    req_miso    = '1;
    sdcard_cs   = IDLE_CS;
    sdcard_mosi = IDLE_MOSI;
    sdcard_sclk = IDLE_SCLK;
    if (granted) begin
      req_miso[own_q] = sdcard_miso;
      sdcard_cs       = req_cs[own_q];
      sdcard_mosi     = req_mosi[own_q];
      sdcard_sclk     = req_sclk[own_q];
    end
  end

  assign sdack = ack_q;
  assign busy  = busy_q;
  assign owner = OWN_W'(own_q);
endmodule

// File: tb/tb_sdcard_arbiter.sv
// Directed self-checking bench for sdcard_arbiter (NREQ=4, GUARD=8).
module tb_sdcard_arbiter;
  localparam int NREQ  = 4;
  localparam int GUARD = 8;

  logic             clk_p = 1'b0;
  logic             sys_init_n = 1'b0;
  logic [NREQ-1:0]  sdreq = '0;
  logic [NREQ-1:0]  req_cs = '1;
  logic [NREQ-1:0]  req_mosi = '1;
  logic [NREQ-1:0]  req_sclk = '0;
  logic             sdcard_miso = 1'b1;
  logic [NREQ-1:0]  sdack;
  logic [NREQ-1:0]  req_miso;
  logic             sdcard_cs, sdcard_mosi, sdcard_sclk;
  logic [2:0]       owner;
  logic             busy, timeout;

  int n_chk  = 0;
  int n_fail = 0;

  sdcard_arbiter #(
    .NREQ(NREQ), .GUARD(GUARD)
`ifdef SDARB_TIMEOUT_EN
    , .TIMEOUT(24'd100)
`endif
  ) dut (
    .clk_p(clk_p), .sys_init_n(sys_init_n), .sdreq(sdreq), .sdack(sdack),
    .req_cs(req_cs), .req_mosi(req_mosi), .req_sclk(req_sclk), .req_miso(req_miso),
    .sdcard_cs(sdcard_cs), .sdcard_mosi(sdcard_mosi), .sdcard_sclk(sdcard_sclk),
    .sdcard_miso(sdcard_miso), .owner(owner), .busy(busy), .timeout(timeout)
  );

  always #5 clk_p = ~clk_p;

  task automatic tick;
    @(negedge clk_p);
  endtask

  task automatic wait_ack(input int maxc, output int cnt);
    cnt = 0;
    while (sdack == '0 && cnt < maxc) begin
      tick();
      cnt++;
    end
  endtask

  // Counts idle samples until the next grant, re-raising sdreq to nxt after the first edge.
  task automatic gap(input logic [NREQ-1:0] nxt, output int cnt, output int bad);
    cnt = 0;
    bad = 0;
    tick();
    sdreq = nxt;
    while (sdack == '0 && cnt < 60) begin
      cnt++;
      if (sdcard_cs !== 1'b1 || sdcard_sclk !== 1'b0 || sdcard_mosi !== 1'b1 || req_miso !== 4'hF) bad++;
      tick();
    end
  endtask

  task automatic settle;
    sdreq = '0;
    repeat (GUARD + 3) tick();
  endtask

  task automatic test_reset;
    sys_init_n = 1'b0;
    tick(); tick();
    n_chk++; if (sdack !== 4'b0000) begin n_fail++; $display("FAIL reset_sdack: got %b want 0000", sdack); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (owner !== 3'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner); end
    n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    n_chk++; if ({sdcard_cs, sdcard_mosi, sdcard_sclk} !== 3'b110) begin
      n_fail++; $display("FAIL reset_pins: got cs/mosi/sclk %b want 110", {sdcard_cs, sdcard_mosi, sdcard_sclk}); end
    n_chk++; if (req_miso !== 4'hF) begin n_fail++; $display("FAIL reset_miso: got %b want 1111", req_miso); end
    sys_init_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    tick();
    sdreq = 4'b0010; req_cs = 4'b1101; req_mosi = 4'b0010; req_sclk = 4'b0010; sdcard_miso = 1'b0;
    #1;
    n_chk++; if (sdack !== 4'b0000 || sdcard_cs !== 1'b1) begin
      n_fail++; $display("FAIL single_early: got sdack %b cs %b want 0000 1", sdack, sdcard_cs); end
    tick();
    n_chk++; if (sdack !== 4'b0010 || busy !== 1'b1 || owner !== 3'd1) begin
      n_fail++; $display("FAIL single_grant: got sdack %b busy %b owner %0d want 0010 1 1", sdack, busy, owner); end
    n_chk++; if ({sdcard_cs, sdcard_mosi, sdcard_sclk} !== 3'b011 || req_miso !== 4'b1101) begin
      n_fail++; $display("FAIL single_mux_a: got pins %b miso %b want 011 1101", {sdcard_cs, sdcard_mosi, sdcard_sclk}, req_miso); end
    req_cs = 4'b0010; req_mosi = 4'b1101; req_sclk = 4'b1101; sdcard_miso = 1'b1;
    #1;
    n_chk++; if ({sdcard_cs, sdcard_mosi, sdcard_sclk} !== 3'b100 || req_miso !== 4'b1111) begin
      n_fail++; $display("FAIL single_mux_b: got pins %b miso %b want 100 1111", {sdcard_cs, sdcard_mosi, sdcard_sclk}, req_miso); end
    sdreq = 4'b0000; req_cs = 4'b1101; req_mosi = 4'b0010; req_sclk = 4'b0010; sdcard_miso = 1'b0;
    tick();
    n_chk++; if (sdack !== 4'b0000 || busy !== 1'b0 || {sdcard_cs, sdcard_mosi, sdcard_sclk} !== 3'b110 || req_miso !== 4'hF) begin
      n_fail++; $display("FAIL single_release: got sdack %b busy %b pins %b miso %b want 0000 0 110 1111",
                         sdack, busy, {sdcard_cs, sdcard_mosi, sdcard_sclk}, req_miso); end
    settle();
  endtask

  task automatic test_glitch;
    int c, b;
    tick();
    sdreq = 4'b0010;
    tick();
    n_chk++; if (sdack !== 4'b0010) begin n_fail++; $display("FAIL glitch_pulse: got %b want 0010", sdack); end
    sdreq = 4'b0000;
    gap(4'b0010, c, b);
    n_chk++; if (c !== GUARD + 1 || b !== 0 || sdack !== 4'b0010) begin
      n_fail++; $display("FAIL glitch_guard: got gap %0d badpins %0d sdack %b want 9 0 0010", c, b, sdack); end
    settle();
  endtask

  task automatic test_contention;
    int c, b, unstable;
    logic [NREQ-1:0] exp_seq [3];
    logic [NREQ-1:0] cur;
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b1000; exp_seq[2] = 4'b0001;
    tick();
    sdreq = 4'b1000;
    wait_ack(5, c);
    n_chk++; if (sdack !== 4'b1000) begin n_fail++; $display("FAIL cont_pre: got %b want 1000", sdack); end
    sdreq = 4'b0011;
    gap(4'b1011, c, b);
    n_chk++; if (c !== GUARD + 1 || b !== 0 || sdack !== 4'b0001) begin
      n_fail++; $display("FAIL cont_first: got gap %0d badpins %0d sdack %b want 9 0 0001", c, b, sdack); end
    for (int k = 0; k < 3; k++) begin
      cur = sdack;
      unstable = 0;
      repeat (20) begin
        tick();
        if (sdack !== cur) unstable++;
      end
      sdreq = 4'b1011 & ~cur;
      gap(4'b1011, c, b);
      n_chk++; if (unstable !== 0 || c !== GUARD + 1 || b !== 0 || sdack !== exp_seq[k]) begin
        n_fail++; $display("FAIL cont_step%0d: got unstable %0d gap %0d badpins %0d sdack %b want 0 9 0 %b",
                           k, unstable, c, b, sdack, exp_seq[k]); end
    end
    settle();
  endtask

  task automatic test_back_to_back;
    int c, b;
    tick();
    sdreq = 4'b0100;
    wait_ack(5, c);
    n_chk++; if (sdack !== 4'b0100) begin n_fail++; $display("FAIL b2b_grant2: got %b want 0100", sdack); end
    sdreq = 4'b0101;
    repeat (3) tick();
    n_chk++; if (sdack !== 4'b0100) begin n_fail++; $display("FAIL b2b_nopreempt: got %b want 0100", sdack); end
    sdreq = 4'b0001;
    gap(4'b0101, c, b);
    n_chk++; if (c !== GUARD + 1 || sdack !== 4'b0001) begin
      n_fail++; $display("FAIL b2b_other_first: got gap %0d sdack %b want 9 0001", c, sdack); end
    sdreq = 4'b0100;
    gap(4'b0100, c, b);
    n_chk++; if (c !== GUARD + 1 || b !== 0 || sdack !== 4'b0100) begin
      n_fail++; $display("FAIL b2b_regrant2: got gap %0d badpins %0d sdack %b want 9 0 0100", c, b, sdack); end
    settle();
  endtask

  task automatic test_reset_mid;
    int c;
    req_cs = 4'b0000;
    tick();
    sdreq = 4'b0100;
    wait_ack(5, c);
    n_chk++; if (sdack !== 4'b0100 || sdcard_cs !== 1'b0) begin
      n_fail++; $display("FAIL rmid_grant: got sdack %b cs %b want 0100 0", sdack, sdcard_cs); end
    #2 sys_init_n = 1'b0;
    #1;
    n_chk++; if (sdack !== 4'b0000 || sdcard_cs !== 1'b1 || busy !== 1'b0 || owner !== 3'd0) begin
      n_fail++; $display("FAIL rmid_async: got sdack %b cs %b busy %b owner %0d want 0000 1 0 0",
                         sdack, sdcard_cs, busy, owner); end
    sdreq = 4'b0101;
    tick(); tick();
    sys_init_n = 1'b1;
    wait_ack(5, c);
    n_chk++; if (sdack !== 4'b0100) begin n_fail++; $display("FAIL rmid_first: got %b want 0100", sdack); end
    settle();
    req_cs = 4'b1111;
  endtask

`ifdef SDARB_TIMEOUT_EN
  task automatic test_timeout;
    int c, held, bad;
    tick();
    sdreq = 4'b1000;
    wait_ack(20, c);
    n_chk++; if (sdack !== 4'b1000) begin n_fail++; $display("FAIL tmo_grant: got %b want 1000", sdack); end
    held = 1;
    while (sdack[3] === 1'b1 && held < 300) begin
      tick();
      if (sdack[3] === 1'b1) held++;
    end
    n_chk++; if (held !== 100 || timeout !== 1'b1) begin
      n_fail++; $display("FAIL tmo_release: got held %0d timeout %b want 100 1", held, timeout); end
    tick();
    n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse: got %b want 0", timeout); end
    bad = 0;
    repeat (25) begin
      tick();
      if (sdack !== 4'b0000) bad++;
    end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL tmo_masked: got %0d grant cycles want 0", bad); end
    sdreq = 4'b0000;
    tick();
    sdreq = 4'b1000;
    wait_ack(20, c);
    n_chk++; if (sdack !== 4'b1000) begin n_fail++; $display("FAIL tmo_regrant: got %b want 1000", sdack); end
    settle();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_contention();
    test_back_to_back();
    test_reset_mid();
`ifdef SDARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
